// File: rtl/hazard_stall_controller_if.sv
// Decode-side bundle between the pipeline and hazard_stall_controller.
// master drives decode/execute status; slave is the controller producing stall and flush strobes.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_branch;
  logic             ex_resolve_valid;
  logic             ex_taken;
  logic             stall_if_out;
  logic             stall_id_out;
  logic             bubble_ex_out;
  logic             flush_if_out;
  logic [31:0]      pending_mask_out;
  logic             state_out;
  logic             error_out;
  logic [CNT_W-1:0] stall_count_out;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_branch, ex_resolve_valid, ex_taken,
    input  stall_if_out, stall_id_out, bubble_ex_out, flush_if_out,
           pending_mask_out, state_out, error_out, stall_count_out
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_branch, ex_resolve_valid, ex_taken,
    output stall_if_out, stall_id_out, bubble_ex_out, flush_if_out,
           pending_mask_out, state_out, error_out, stall_count_out
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Central hazard scheduler beside decode: RAW scoreboard without forwarding, branch hold
// until execute resolves, and the stall/bubble/flush strobes for fetch and decode.
module hazard_stall_controller #(
  parameter int WB_DEPTH       = 3,
  parameter int BRANCH_TIMEOUT = 8,
  parameter int CNT_W          = 16
) (
  input logic                      clk,
  input logic                      rst,
  hazard_stall_controller_if.slave bus
);
  localparam int TO_W = $clog2(BRANCH_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BRANCH_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN         = 1'b0,
    ST_BRANCH_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [WB_DEPTH-1:0] slot_vld_q, slot_vld_d;
  logic [4:0]        slot_rd_q [WB_DEPTH];
  logic [4:0]        slot_rd_d [WB_DEPTH];

  logic [31:0] pending_mask;
  logic        match_rs1, match_rs2;
  logic        hazard, accept, stall_id, in_wait;

  // Slots never hold x0, so the mask doubles as the match table; x0 is still excluded explicitly.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (slot_vld_q[i]) pending_mask[slot_rd_q[i]] = 1'b1;
    end
  end

  always_comb begin
    match_rs1 = (bus.id_rs1 != 5'd0) && pending_mask[bus.id_rs1];
    match_rs2 = (bus.id_rs2 != 5'd0) && pending_mask[bus.id_rs2];
    hazard    = bus.id_valid && ((bus.id_uses_rs1 && match_rs1) ||
                                 (bus.id_uses_rs2 && match_rs2));
    in_wait   = (state_q == ST_BRANCH_WAIT);
    accept    = bus.id_valid && !in_wait && !hazard;
    stall_id  = bus.id_valid && !accept;
  end

  // Writers advance one slot per cycle regardless of stalls; the last slot retires into the regfile.
  always_comb begin
    slot_vld_d    = '0;
    slot_vld_d[0] = accept && bus.id_reg_write && (bus.id_rd != 5'd0);
    slot_rd_d[0]  = bus.id_rd;
    for (int i = 1; i < WB_DEPTH; i++) begin
      slot_vld_d[i] = slot_vld_q[i-1];
      slot_rd_d[i]  = slot_rd_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    error_d     = error_q;
    stall_cnt_d = stall_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    case (state_q)
      ST_RUN: begin
        // A resolve with nothing outstanding is a protocol violation, not a control event.
        if (bus.ex_resolve_valid) error_d = 1'b1;
        if (accept && bus.id_branch) begin
          state_d  = ST_BRANCH_WAIT;
          to_cnt_d = '0;
        end
      end
      ST_BRANCH_WAIT: begin
        if (bus.ex_resolve_valid) begin
          state_d  = ST_RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = ST_RUN;
          to_cnt_d = '0;
          error_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d  = ST_RUN;
        to_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      to_cnt_q    <= '0;
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
      slot_vld_q  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) slot_rd_q[i] <= 5'd0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      error_q     <= error_d;
      stall_cnt_q <= stall_cnt_d;
      slot_vld_q  <= slot_vld_d;
      for (int i = 0; i < WB_DEPTH; i++) slot_rd_q[i] <= slot_rd_d[i];
    end
  end

  assign bus.stall_id_out     = stall_id;
  assign bus.bubble_ex_out    = !accept;
  assign bus.stall_if_out     = stall_id || in_wait;
  assign bus.flush_if_out     = in_wait && bus.ex_resolve_valid && bus.ex_taken;
  assign bus.pending_mask_out = pending_mask;
  assign bus.state_out        = state_q;
  assign bus.error_out        = error_q;
  assign bus.stall_count_out  = stall_cnt_q;
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central hazard scheduler for the 5-stage pipeline. Sits beside the decode stage.
- Tracks in-flight register writers in a scoreboard. Detects read-after-write hazards against decode-stage source registers.
- Sequences control-hazard handling: holds fetch from branch/jump decode until execute resolves it.
- Drives stall, bubble-injection and flush strobes for the fetch and decode stages.

Parameters:
WB_DEPTH, 3, scoreboard slots between decode and register-file write (EX, MEM, WB).
BRANCH_TIMEOUT, 8, max BRANCH_WAIT cycles before a protocol error is flagged.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
id_valid  input  1  decode holds a valid instruction.
id_rs1  input  5  source register 1 index.
id_rs2  input  5  source register 2 index.
id_uses_rs1  input  1  instruction reads rs1.
id_uses_rs2  input  1  instruction reads rs2.
id_rd  input  5  destination register index.
id_reg_write  input  1  instruction writes rd.
id_branch  input  1  instruction is a branch or jump.
ex_resolve_valid  input  1  execute resolves the outstanding branch this cycle.
ex_taken  input  1  resolved branch is taken (qualified by ex_resolve_valid).
stall_if_out  output  1  hold PC and the IF/ID register.
stall_id_out  output  1  decode instruction not accepted; hold it.
bubble_ex_out  output  1  load NOP into ID/EX this cycle.
flush_if_out  output  1  discard the wrong-path instruction in IF/ID.
pending_mask_out  output  32  bit r set if any valid scoreboard slot targets xr.
state_out  output  1  0=RUN, 1=BRANCH_WAIT.
error_out  output  1  sticky protocol error.
stall_count_out  output  CNT_W  cycles with stall_id_out=1, saturating.

Behaviour:
- Reset (async, immediate on rst=1):
  - state RUN; all scoreboard slots invalid; timeout counter 0; stall_count_out 0; error_out 0.
  - While in reset, the combinational outputs follow from the reset state and the inputs; there are no separate reset values.
  - With id_valid=0 during reset: stall_if_out=0, stall_id_out=0, flush_if_out=0, bubble_ex_out=1, pending_mask_out=0.
- Scoreboard: slots 0..WB_DEPTH-1, each {valid, rd}. Every clock:
  - slot[i+1] <= slot[i]; slot[WB_DEPTH-1] retires.
  - slot[0] <= {accept & id_reg_write & (id_rd != 0), id_rd}.
- No forwarding exists. A write is visible to decode only after its slot has retired.
- match(r) = (r != 0) & any valid slot with rd == r. x0 never hazards.
- hazard = id_valid & ((id_uses_rs1 & match(id_rs1)) | (id_uses_rs2 & match(id_rs2))).
- accept = id_valid & (state == RUN) & !hazard.
- Combinational outputs, same cycle as inputs:
  - stall_id_out = id_valid & !accept.
  - bubble_ex_out = !accept.
  - stall_if_out = stall_id_out | (state == BRANCH_WAIT).
  - flush_if_out = (state == BRANCH_WAIT) & ex_resolve_valid & ex_taken.
- FSM:
  - RUN -> BRANCH_WAIT when accept & id_branch. Timeout counter cleared.
  - BRANCH_WAIT -> RUN when ex_resolve_valid. Counter cleared.
  - BRANCH_WAIT -> RUN when the counter reaches BRANCH_TIMEOUT-1 without a resolve; error_out set.
  - Otherwise in BRANCH_WAIT the counter increments.
- Simultaneous events:
  - A resolve and id_valid in the same BRANCH_WAIT cycle: the instruction is not accepted that cycle. It is evaluated in RUN next cycle. If ex_taken, the IF stage is flushed and decode re-presents the correct-path instruction.
  - ex_resolve_valid while in RUN: ignored for control; sets error_out.
- Branch that also writes rd (JAL/JALR): enters the scoreboard like any writer.
- stall_count_out increments when stall_id_out=1 and saturates at all-ones.
- error_out clears only on rst.

Test Plan:
1. Accept writer rd=5 at cycle 0; at cycle 1 present reader rs1=5, uses_rs1=1 -> stall_id_out=1 and bubble_ex_out=1 for cycles 1-3; accepted at cycle 4; stall_count_out=3; pending_mask_out bit5 set for cycles 1-3.
2. Writer rd=0, then reader rs1=0 -> no stall; pending_mask_out stays 0. Reader rs2=5 with uses_rs2=0 after writer rd=5 -> no stall.
3. Accept branch at cycle 0 -> state_out=1, stall_if_out=1 from cycle 1. At cycle 2 drive ex_resolve_valid=1, ex_taken=1 -> flush_if_out=1 in cycle 2; state_out=0 at cycle 3. Same scenario with ex_taken=0 -> flush_if_out stays 0.
4. Accept branch, never resolve -> state_out returns to 0 after 8 cycles in BRANCH_WAIT; error_out=1 and stays 1.
5. Drive ex_resolve_valid=1 while in RUN -> error_out=1; state_out unchanged.
6. Assert rst mid-BRANCH_WAIT with 3 valid slots -> immediately state_out=0, pending_mask_out=0, stall_count_out=0, error_out=0. A reader of the former rd is accepted on the first cycle after rst deasserts.
